// File: rtl/oclib_uart_tx_cfg.sv
// Runtime-configurable UART transmitter: programmable divisor, 5..MaxDataBits data bits,
// parity none/even/odd/mark, 1 or 2 stop bits, break generation and an occupancy-reporting TX FIFO.
module oclib_uart_tx_cfg #(
    parameter int unsigned DivWidth    = 16,
    parameter int unsigned MaxDataBits = 9,
    parameter int unsigned FifoDepth   = 16,
    parameter int unsigned CountWidth  = $clog2(FifoDepth + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DivWidth-1:0]    cfgDivisor,
    input  logic [3:0]             cfgDataBits,
    input  logic [1:0]             cfgParity,
    input  logic                   cfgStop2,
    input  logic                   sendBreak,
    input  logic [MaxDataBits-1:0] txData,
    input  logic                   txValid,
    output logic                   txReady,
    output logic                   tx,
    output logic                   busy,
    output logic [CountWidth-1:0]  fifoCount
);

    localparam int unsigned PtrWidth = $clog2(FifoDepth);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    state_t                 state_q, state_d;
    logic [DivWidth-1:0]    cnt_q, cnt_d, dm1_q, dm1_d;
    logic [3:0]             nbits_q, nbits_d, idx_q, idx_d;
    logic [1:0]             par_q, par_d;
    logic                   stop2_q, stop2_d, mark_q, mark_d, brk_req_q, brk_req_d;
    logic [MaxDataBits-1:0] data_q, data_d;
    logic [MaxDataBits-1:0] mem_q [FifoDepth];
    logic [PtrWidth-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CountWidth-1:0]  count_q, count_d;
    logic                   ready_q, tx_q, tx_d, busy_q, busy_d;
    logic                   push, pop, tick, eval_idle, par_bit;
    logic [DivWidth-1:0]    cfg_dm1;
    logic [3:0]             cfg_n;
    logic [MaxDataBits-1:0] head_masked;

    assign push      = txValid && ready_q;
    assign tick      = (cnt_q == '0);
    assign count_d   = count_q + CountWidth'(push) - CountWidth'(pop);
    assign txReady   = ready_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign fifoCount = count_q;

    // Clamp live configuration; it is only sampled when a frame or break begins
    always_comb begin
        cfg_dm1 = (cfgDivisor < DivWidth'(2)) ? DivWidth'(1) : cfgDivisor - DivWidth'(1);
        if (cfgDataBits < 4'd5)                    cfg_n = 4'd5;
        else if (cfgDataBits > 4'(MaxDataBits))    cfg_n = 4'(MaxDataBits);
        else                                       cfg_n = cfgDataBits;
        for (int i = 0; i < int'(MaxDataBits); i++) begin
            head_masked[i] = mem_q[rd_ptr_q][i] & (i < int'(cfg_n));
        end
    end

    always_comb begin
        unique case (par_q)
            2'd1:    par_bit = ^data_q;
            2'd2:    par_bit = ~^data_q;
            default: par_bit = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dm1_d     = dm1_q;
        nbits_d   = nbits_q;
        par_d     = par_q;
        stop2_d   = stop2_q;
        data_d    = data_q;
        idx_d     = idx_q;
        mark_d    = mark_q;
        brk_req_d = brk_req_q;
        pop       = 1'b0;
        eval_idle = 1'b0;
        // A break request seen mid-frame is held until the frame's stop bits finish
        if (state_q != S_BREAK && sendBreak) brk_req_d = 1'b1;
        unique case (state_q)
            S_IDLE: eval_idle = 1'b1;
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    cnt_d   = dm1_q;
                    idx_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - DivWidth'(1);
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_d = dm1_q;
                    if (idx_q == nbits_q - 4'd1) begin
                        idx_d   = 4'd0;
                        state_d = (par_q != 2'd0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q - DivWidth'(1);
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    cnt_d   = dm1_q;
                    idx_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - DivWidth'(1);
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (stop2_q && idx_q == 4'd0) begin
                        idx_d = 4'd1;
                        cnt_d = dm1_q;
                    end else begin
                        eval_idle = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - DivWidth'(1);
                end
            end
            S_BREAK: begin
                if (!tick) begin
                    cnt_d = cnt_q - DivWidth'(1);
                end else if (mark_q) begin
                    eval_idle = 1'b1;
                end else if (!sendBreak) begin
                    mark_d = 1'b1;
                    cnt_d  = dm1_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Idle decision, also taken on the last stop/mark cycle for zero-gap chaining
        if (eval_idle) begin
            if (sendBreak || brk_req_q) begin
                state_d   = S_BREAK;
                cnt_d     = cfg_dm1;
                dm1_d     = cfg_dm1;
                mark_d    = 1'b0;
                brk_req_d = 1'b0;
            end else if (count_q != '0) begin
                pop     = 1'b1;
                state_d = S_START;
                cnt_d   = cfg_dm1;
                dm1_d   = cfg_dm1;
                nbits_d = cfg_n;
                par_d   = cfgParity;
                stop2_d = cfgStop2;
                data_d  = head_masked;
                idx_d   = 4'd0;
            end else begin
                state_d = S_IDLE;
            end
        end
        unique case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_q[idx_q];
            S_PARITY: tx_d = par_bit;
            S_BREAK:  tx_d = mark_q;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_q != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= txData;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dm1_q     <= '0;
            nbits_q   <= 4'd0;
            par_q     <= 2'd0;
            stop2_q   <= 1'b0;
            data_q    <= '0;
            idx_q     <= 4'd0;
            mark_q    <= 1'b0;
            brk_req_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dm1_q     <= dm1_d;
            nbits_q   <= nbits_d;
            par_q     <= par_d;
            stop2_q   <= stop2_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            mark_q    <= mark_d;
            brk_req_q <= brk_req_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            count_q   <= count_d;
            ready_q   <= (count_d != CountWidth'(FifoDepth));
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_oclib_uart_tx_cfg.sv
// Directed bench for oclib_uart_tx_cfg: expected frames are queued when words are pushed
// and a line monitor checks tx cycle by cycle against them.
module tb_oclib_uart_tx_cfg;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] cfgDivisor = 16'd4;
    logic [3:0]  cfgDataBits = 4'd8;
    logic [1:0]  cfgParity = 2'd0;
    logic        cfgStop2 = 1'b0;
    logic        sendBreak = 1'b0;
    logic [8:0]  txData = '0;
    logic        txValid = 1'b0;
    logic        txReady, tx, busy;
    logic [4:0]  fifoCount;

    typedef struct {
        bit         brk;
        int         d;
        int         n;
        int         par;
        bit         stop2;
        logic [8:0] data;
        bit         b2b;
        int         exp_low;
    } item_t;

    item_t sb[$];
    int    nchecks = 0;
    int    nfail   = 0;
    int    cyc     = 0;
    int    last_end = -100;

    oclib_uart_tx_cfg dut (
        .clock(clock), .reset(reset), .cfgDivisor(cfgDivisor), .cfgDataBits(cfgDataBits),
        .cfgParity(cfgParity), .cfgStop2(cfgStop2), .sendBreak(sendBreak), .txData(txData),
        .txValid(txValid), .txReady(txReady), .tx(tx), .busy(busy), .fifoCount(fifoCount)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input item_t it, input int c);
        int b;
        logic [8:0] m;
        b = c / it.d;
        m = '0;
        for (int i = 0; i < it.n; i++) m[i] = it.data[i];
        if (b == 0) return 1'b0;
        if (b <= it.n) return it.data[b-1];
        if (it.par != 0 && b == it.n + 1) begin
            if (it.par == 1) return ^m;
            if (it.par == 2) return ~^m;
            return 1'b1;
        end
        return 1'b1;
    endfunction

    // Line monitor: every low excursion must be the head expected frame or break
    initial begin : monitor
        item_t it;
        int total, mism, low, start;
        bit aborted;
        forever begin
            @(negedge clock);
            if (!reset) continue;
            if (tx === 1'b0) begin
                if (sb.size() == 0) begin
                    check("unexpected_low", 32'(tx), 32'd1);
                    continue;
                end
                it = sb[0];
                aborted = 1'b0;
                start = cyc;
                mism = 0;
                if (it.b2b) check("b2b_gap", 32'(start), 32'(last_end + 1));
                if (!it.brk) begin
                    total = it.d * (1 + it.n + ((it.par != 0) ? 1 : 0) + 1 + (it.stop2 ? 1 : 0));
                    for (int c = 0; c < total; c++) begin
                        if (c > 0) @(negedge clock);
                        if (!reset) begin aborted = 1'b1; break; end
                        if (tx !== exp_bit(it, c)) mism++;
                    end
                    if (!aborted) check("frame_bits", 32'(mism), 32'd0);
                end else begin
                    low = 0;
                    while (tx === 1'b0 && low < 5000) begin
                        low++;
                        @(negedge clock);
                        if (!reset) begin aborted = 1'b1; break; end
                    end
                    if (!aborted) begin
                        check("break_min_low", 32'(low >= it.d), 32'd1);
                        if (it.exp_low != 0) check("break_low_len", 32'(low), 32'(it.exp_low));
                        for (int c = 0; c < it.d; c++) begin
                            if (c > 0) @(negedge clock);
                            if (!reset) begin aborted = 1'b1; break; end
                            if (tx !== 1'b1) mism++;
                        end
                        if (!aborted) check("break_mark", 32'(mism), 32'd0);
                    end
                end
                if (!aborted) begin
                    last_end = cyc;
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic expect_item(input bit brk, input int d, input int n, input int par,
                               input bit stop2, input logic [8:0] data, input bit b2b,
                               input int exp_low);
        item_t it;
        it.brk = brk; it.d = d; it.n = n; it.par = par; it.stop2 = stop2;
        it.data = data; it.b2b = b2b; it.exp_low = exp_low;
        sb.push_back(it);
    endtask

    task automatic push_word(input logic [8:0] data, input int d, input int n, input int par,
                             input bit stop2, input bit b2b);
        int w;
        expect_item(1'b0, d, n, par, stop2, data, b2b, 0);
        w = 0;
        while (txReady !== 1'b1 && w < 2000) begin
            @(posedge clock); #1;
            w++;
        end
        if (w >= 2000) check("push_ready_timeout", 32'(txReady), 32'd1);
        txValid = 1'b1;
        txData  = data;
        @(posedge clock); #1;
        txValid = 1'b0;
    endtask

    task automatic wait_busy();
        int w;
        w = 0;
        while (busy !== 1'b1 && w < 200) begin
            @(posedge clock); #1;
            w++;
        end
        if (w >= 200) check("busy_timeout", 32'(busy), 32'd1);
    endtask

    task automatic wait_drain(input int bound);
        int w;
        w = 0;
        while ((sb.size() != 0 || busy !== 1'b0 || fifoCount != 5'd0) && w < bound) begin
            @(posedge clock); #1;
            w++;
        end
        check("drain", 32'((sb.size() == 0) && (busy === 1'b0)), 32'd1);
    endtask

    initial begin : stimulus
        int nb;
        int w;
        // reset state
        #12;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(txReady), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifoCount), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        check("ready_before_edge", 32'(txReady), 32'd0);
        @(posedge clock); #1;
        check("ready_after_release", 32'(txReady), 32'd1);

        // 8N1, D=4, latency and busy width
        cfgDivisor = 16'd4; cfgDataBits = 4'd8; cfgParity = 2'd0; cfgStop2 = 1'b0;
        push_word(9'h0A5, 4, 8, 0, 1'b0, 1'b0);
        @(posedge clock); #1;
        check("latency_k1_high", 32'(tx), 32'd1);
        @(posedge clock); #1;
        check("latency_k2_low", 32'(tx), 32'd0);
        nb = 0;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            @(posedge clock); #1;
        end
        check("busy_cycles", 32'(nb), 32'd40);
        wait_drain(200);

        // 7 data bits, D=3, two stop bits, parity even/odd/mark; bits 7,8 must be ignored
        cfgDivisor = 16'd3; cfgDataBits = 4'd7; cfgStop2 = 1'b1;
        for (int p = 1; p <= 3; p++) begin
            cfgParity = 2'(p);
            push_word(9'h1C1, 3, 7, p, 1'b1, 1'b0);
            wait_drain(200);
        end

        // break held while FIFO fills, then 16 back-to-back frames
        cfgDivisor = 16'd2; cfgDataBits = 4'd8; cfgParity = 2'd0; cfgStop2 = 1'b0;
        expect_item(1'b1, 2, 0, 0, 1'b0, 9'h0, 1'b0, 0);
        sendBreak = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        for (int i = 0; i < 16; i++) push_word(9'(i * 37 + 3), 2, 8, 0, 1'b0, i > 0);
        check("full_count", 32'(fifoCount), 32'd16);
        check("full_ready", 32'(txReady), 32'd0);
        check("break_tx", 32'(tx), 32'd0);
        sendBreak = 1'b0;
        w = 0;
        while (fifoCount == 5'd16 && w < 100) begin
            @(posedge clock); #1;
            w++;
        end
        check("first_pop_count", 32'(fifoCount), 32'd15);
        check("first_pop_ready", 32'(txReady), 32'd1);
        wait_drain(1000);
        check("drained_count", 32'(fifoCount), 32'd0);

        // mid-frame config change applies to the next frame only; clamp corners
        cfgDivisor = 16'd4; cfgDataBits = 4'd8;
        push_word(9'h03C, 4, 8, 0, 1'b0, 1'b0);
        wait_busy();
        cfgDivisor = 16'd8; cfgDataBits = 4'd5;
        push_word(9'h0FF, 8, 5, 0, 1'b0, 1'b1);
        wait_drain(300);
        cfgDivisor = 16'd0; cfgDataBits = 4'd2;
        push_word(9'h02A, 2, 5, 0, 1'b0, 1'b0);
        wait_drain(100);
        cfgDivisor = 16'd1; cfgDataBits = 4'd15;
        push_word(9'h155, 2, 9, 0, 1'b0, 1'b0);
        wait_drain(100);

        // asynchronous reset mid-DATA flushes everything
        cfgDivisor = 16'd4; cfgDataBits = 4'd8;
        push_word(9'h000, 4, 8, 0, 1'b0, 1'b0);
        push_word(9'h000, 4, 8, 0, 1'b0, 1'b1);
        wait_busy();
        repeat (10) @(posedge clock);
        #1;
        check("pre_reset_tx", 32'(tx), 32'd0);
        reset = 1'b0;
        #1;
        check("reset_tx_async", 32'(tx), 32'd1);
        check("reset_count_async", 32'(fifoCount), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        sb.delete();
        check("reset_ready_low", 32'(txReady), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        check("reset_ready_rise", 32'(txReady), 32'd1);
        repeat (60) @(posedge clock);
        #1;
        check("no_residual_tx", 32'(tx), 32'd1);
        check("no_residual_busy", 32'(busy), 32'd0);

        // simultaneous push and pop at fifoCount=3
        push_word(9'h011, 4, 8, 0, 1'b0, 1'b0);
        wait_busy();
        push_word(9'h022, 4, 8, 0, 1'b0, 1'b1);
        push_word(9'h033, 4, 8, 0, 1'b0, 1'b1);
        push_word(9'h044, 4, 8, 0, 1'b0, 1'b1);
        repeat (35) @(posedge clock);
        #1;
        check("count_before_pushpop", 32'(fifoCount), 32'd3);
        expect_item(1'b0, 4, 8, 0, 1'b0, 9'h055, 1'b1, 0);
        txValid = 1'b1;
        txData  = 9'h055;
        @(posedge clock); #1;
        txValid = 1'b0;
        check("count_after_pushpop", 32'(fifoCount), 32'd3);
        wait_drain(400);

        // one-cycle break pulse mid-frame: frame completes, then D low and D mark
        push_word(9'h00F, 4, 8, 0, 1'b0, 1'b0);
        wait_busy();
        repeat (5) @(posedge clock);
        #1;
        expect_item(1'b1, 4, 0, 0, 1'b0, 9'h0, 1'b1, 4);
        sendBreak = 1'b1;
        @(posedge clock); #1;
        sendBreak = 1'b0;
        wait_drain(200);
        check("final_tx_idle", 32'(tx), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule
